// File: rtl/vram_blit_if.sv
// Video RAM master bus of the block-copy/fill engine: arbiter request/grant
// plus the byte-wide sel_ram/we/addr/din/ram_dout cycle signals.
interface vram_blit_if #(
    parameter int AW = 13
);
    // busreq is raised from START until DONE.  The engine issues a RAM strobe
    // (m_sel_ram, with m_we for writes) only in a cycle it entered while busgnt
    // was high.  m_rdata is sampled RD_LAT cycles after a read strobe.
    logic          busreq;
    logic          busgnt;
    logic          m_sel_ram;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_din;
    logic [7:0]    m_rdata;

    modport master (
        output busreq, m_sel_ram, m_we, m_addr, m_din,
        input  busgnt, m_rdata
    );

    modport slave (
        input  busreq, m_sel_ram, m_we, m_addr, m_din,
        output busgnt, m_rdata
    );
endinterface

// File: rtl/vram_blit.sv
// CPU-programmed block copy / fill engine that masters the video RAM CPU port.
// Register file at addr 0..7, working counters, and a per-byte REQ/RD/WR FSM.
module vram_blit #(
    parameter int RD_LAT = 2,
    parameter int AW     = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel_ctl,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [7:0]  din,
    output logic [7:0]  ctl_dout,
    output logic        irq,
    output logic [2:0]  dbg_state,
    vram_blit_if.master ram
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_RD    = 3'd2,
        S_RWAIT = 3'd3,
        S_WR    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state, state_nx;

    // programmed registers
    logic [AW-1:0] src, dst, len;
    logic [7:0]    fill;
    logic          mode, dir, irqen;

    // working state
    logic [AW-1:0] src_cnt, dst_cnt, len_cnt;
    logic [7:0]    data_reg;
    logic          have_data;
    logic [2:0]    wait_cnt;
    logic          done, irq_r;

    // decoded control
    logic          busy;
    logic          reg_wr, ctl_wr, stat_rd;
    logic          start, abort, clr_flags, irqen_now;
    logic          load, latch, step_wr, finish, start_empty, set_flags;
    logic [15:0]   src16, dst16, len16;
    logic [7:0]    status;

    assign busy      = (state == S_REQ) || (state == S_RD) ||
                       (state == S_RWAIT) || (state == S_WR);
    assign reg_wr    = sel_ctl && we;
    assign ctl_wr    = reg_wr && (addr == 3'd7);
    assign stat_rd   = sel_ctl && !we && (addr == 3'd7);
    assign start     = ctl_wr && din[0] && (state == S_IDLE);
    assign abort     = ctl_wr && din[3] && busy;
    assign clr_flags = stat_rd || start;
    assign irqen_now = ctl_wr ? din[4] : irqen;
    assign set_flags = finish || start_empty;

    assign src16  = 16'(src);
    assign dst16  = 16'(dst);
    assign len16  = 16'(len);
    assign status = {busy, done, 1'b0, irqen, dir, mode, 2'b00};

    assign dbg_state = state;
    assign irq       = irq_r;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        load        = 1'b0;
        latch       = 1'b0;
        step_wr     = 1'b0;
        start_empty = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        start_empty = 1'b1;
                    end else begin
                        load     = 1'b1;
                        state_nx = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // A byte already read before a grant drop goes straight to its write.
                if (abort) begin
                    state_nx = S_DONE;
                end else if (ram.busgnt) begin
                    state_nx = (mode || have_data) ? S_WR : S_RD;
                end
            end
            S_RD: begin
                if (abort) begin
                    state_nx = S_DONE;
                end else if (RD_LAT == 1) begin
                    latch    = 1'b1;
                    state_nx = ram.busgnt ? S_WR : S_REQ;
                end else begin
                    state_nx = S_RWAIT;
                end
            end
            S_RWAIT: begin
                if (abort) begin
                    state_nx = S_DONE;
                end else if (wait_cnt == 3'(RD_LAT - 2)) begin
                    latch    = 1'b1;
                    state_nx = ram.busgnt ? S_WR : S_REQ;
                end
            end
            S_WR: begin
                step_wr = 1'b1;
                if (abort || (len_cnt == AW'(1))) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_REQ;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign finish = (state_nx == S_DONE) && (state != S_DONE);

    // ------------------------------------------------------------------
    // RAM bus outputs: strobes and address only during RD / WR cycles
    // ------------------------------------------------------------------
    assign ram.busreq    = busy;
    assign ram.m_sel_ram = (state == S_RD) || (state == S_WR);
    assign ram.m_we      = (state == S_WR);
    assign ram.m_addr    = (state == S_RD) ? src_cnt :
                           (state == S_WR) ? dst_cnt : '0;
    assign ram.m_din     = (state == S_WR) ? (mode ? fill : data_reg) : 8'h00;

    // ------------------------------------------------------------------
    // Register file; only ABORT and IRQEN are accepted while busy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            src   <= '0;
            dst   <= '0;
            len   <= '0;
            fill  <= 8'h00;
            mode  <= 1'b0;
            dir   <= 1'b0;
            irqen <= 1'b0;
        end else if (reg_wr && !busy) begin
            case (addr)
                3'd0: src[7:0]    <= din;
                3'd1: src[AW-1:8] <= din[AW-9:0];
                3'd2: dst[7:0]    <= din;
                3'd3: dst[AW-1:8] <= din[AW-9:0];
                3'd4: len[7:0]    <= din;
                3'd5: len[AW-1:8] <= din[AW-9:0];
                3'd6: fill        <= din;
                3'd7: begin
                    mode  <= din[1];
                    dir   <= din[2];
                    irqen <= din[4];
                end
                default: ;
            endcase
        end else if (ctl_wr) begin
            irqen <= din[4];
        end
    end

    // ------------------------------------------------------------------
    // Working counters and read data
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            src_cnt   <= '0;
            dst_cnt   <= '0;
            len_cnt   <= '0;
            data_reg  <= 8'h00;
            have_data <= 1'b0;
            wait_cnt  <= 3'd0;
        end else begin
            if (load) begin
                src_cnt   <= src;
                dst_cnt   <= dst;
                len_cnt   <= len;
                have_data <= 1'b0;
            end
            if (state == S_RD) begin
                wait_cnt <= 3'd0;
            end else if (state == S_RWAIT) begin
                wait_cnt <= wait_cnt + 3'd1;
            end
            if (latch) begin
                data_reg  <= ram.m_rdata;
                have_data <= 1'b1;
            end
            // Address counters wrap naturally at AW bits in either direction.
            if (step_wr) begin
                src_cnt   <= dir ? (src_cnt - AW'(1)) : (src_cnt + AW'(1));
                dst_cnt   <= dir ? (dst_cnt - AW'(1)) : (dst_cnt + AW'(1));
                len_cnt   <= len_cnt - AW'(1);
                have_data <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // done / irq flags: a set in the same cycle as a clear wins
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            done  <= 1'b0;
            irq_r <= 1'b0;
        end else begin
            if (set_flags) begin
                done <= 1'b1;
            end else if (clr_flags) begin
                done <= 1'b0;
            end
            if (set_flags && irqen_now) begin
                irq_r <= 1'b1;
            end else if (clr_flags) begin
                irq_r <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register read-back, registered
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctl_dout <= 8'h00;
        end else if (sel_ctl && !we) begin
            case (addr)
                3'd0:    ctl_dout <= src16[7:0];
                3'd1:    ctl_dout <= src16[15:8];
                3'd2:    ctl_dout <= dst16[7:0];
                3'd3:    ctl_dout <= dst16[15:8];
                3'd4:    ctl_dout <= len16[7:0];
                3'd5:    ctl_dout <= len16[15:8];
                3'd6:    ctl_dout <= fill;
                default: ctl_dout <= status;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_blit.sv
// Directed bench for vram_blit: byte RAM and arbiter model, CPU register tasks,
// hand-computed expectations checked with immediate assertions.
`timescale 1ns/1ps
module tb_vram_blit;
  localparam int AW = 13;
  localparam int RD_LAT = 2;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_DONE = 3'd5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sel_ctl = 1'b0;
  logic we = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] ctl_dout;
  logic irq;
  logic [2:0] dbg_state;
  logic gnt_en = 1'b1;

  int n_assert = 0;
  int n_fail = 0;

  logic [7:0] mem [0:8191];
  logic [7:0] exp_mem [0:8191];
  logic [AW-1:0] wr_q[$];
  int wr_cnt = 0;
  int strobe_cnt = 0;
  int breq_cnt = 0;
  logic [7:0] rdata_q = 8'h00;

  vram_blit_if #(.AW(AW)) ram_if();
  assign ram_if.busgnt  = gnt_en & ram_if.busreq;
  assign ram_if.m_rdata = rdata_q;

  vram_blit #(.RD_LAT(RD_LAT), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .sel_ctl   (sel_ctl),
    .we        (we),
    .addr      (addr),
    .din       (din),
    .ctl_dout  (ctl_dout),
    .irq       (irq),
    .dbg_state (dbg_state),
    .ram       (ram_if)
  );

  // clock / reset block
  always #31 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  // RAM model: registered read data (valid the cycle after the strobe)
  always @(posedge clk) begin
    if (ram_if.busreq) breq_cnt++;
    if (ram_if.m_sel_ram) begin
      strobe_cnt++;
      if (ram_if.m_we) begin
        mem[ram_if.m_addr] = ram_if.m_din;
        wr_cnt++;
        wr_q.push_back(ram_if.m_addr);
      end else begin
        rdata_q <= mem[ram_if.m_addr];
      end
    end
  end

  // driver tasks: entered and left on a falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
    sel_ctl = 1'b1; we = 1'b1; addr = a; din = d;
    @(negedge clk);
    sel_ctl = 1'b0; we = 1'b0;
  endtask

  task automatic cpu_rd(input logic [2:0] a, output logic [7:0] d);
    sel_ctl = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    sel_ctl = 1'b0;
    d = ctl_dout;
  endtask

  task automatic set_regs(input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] l, input logic [7:0] f);
    cpu_wr(3'd0, s[7:0]); cpu_wr(3'd1, s[15:8]);
    cpu_wr(3'd2, d[7:0]); cpu_wr(3'd3, d[15:8]);
    cpu_wr(3'd4, l[7:0]); cpu_wr(3'd5, l[15:8]);
    cpu_wr(3'd6, f);
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int cyc);
    cyc = 0;
    while (dbg_state !== s && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("wait_budget", 32'(cyc < budget), 32'd1);
  endtask

  task automatic init_pattern();
    for (int i = 0; i < 8192; i++) begin
      mem[i] = i[7:0];
      exp_mem[i] = i[7:0];
    end
  endtask

  task automatic model_copy(input logic [12:0] s, input logic [12:0] d,
                            input int n, input bit desc);
    logic [12:0] sp, dp;
    sp = s; dp = d;
    for (int k = 0; k < n; k++) begin
      exp_mem[dp] = exp_mem[sp];
      sp = desc ? sp - 13'd1 : sp + 13'd1;
      dp = desc ? dp - 13'd1 : dp + 13'd1;
    end
  endtask

  task automatic model_fill(input logic [12:0] d, input int n, input logic [7:0] f);
    logic [12:0] dp;
    dp = d;
    for (int k = 0; k < n; k++) begin
      exp_mem[dp] = f;
      dp = dp + 13'd1;
    end
  endtask

  function automatic int ram_diff();
    int n = 0;
    for (int i = 0; i < 8192; i++) if (mem[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  initial begin
    logic [7:0] rd;
    int cyc, wb, qb, sb, bb, nw, k;
    logic [12:0] wrap_exp [4];

    // reset state
    init_pattern();
    tick(3);
    check("rst_busreq", ram_if.busreq, 0);
    check("rst_sel", ram_if.m_sel_ram, 0);
    check("rst_we", ram_if.m_we, 0);
    check("rst_addr", ram_if.m_addr, 0);
    check("rst_din", ram_if.m_din, 0);
    check("rst_irq", irq, 0);
    reset = 1'b1;
    tick(1);
    cpu_rd(3'd7, rd); check("rst_status", rd, 8'h00);
    cpu_rd(3'd0, rd); check("rst_src_lo", rd, 8'h00);

    // fill 1024 x 0x20 at 0, IRQEN
    set_regs(16'h0000, 16'h0000, 16'd1024, 8'h20);
    wb = wr_cnt;
    cpu_wr(3'd7, 8'h13);
    wait_state(ST_DONE, 5000, cyc);
    check("fill_cycles", cyc, 2048);
    check("fill_irq", irq, 1);
    check("fill_busreq_done", ram_if.busreq, 0);
    check("fill_writes", wr_cnt - wb, 1024);
    model_fill(13'h0000, 1024, 8'h20);
    check("fill_ram", ram_diff(), 0);
    tick(1);
    check("fill_idle", dbg_state, ST_IDLE);
    cpu_rd(3'd7, rd); check("fill_status", rd, 8'h54);
    check("fill_irq_cleared", irq, 0);

    // scroll copy 0x40 -> 0, 0x3C0 bytes ascending
    init_pattern();
    set_regs(16'h0040, 16'h0000, 16'h03C0, 8'h00);
    cpu_wr(3'd7, 8'h01);
    wait_state(ST_DONE, 5000, cyc);
    check("copy_cycles", cyc, 4 * 32'h3C0);
    check("copy_irq_off", irq, 0);
    model_copy(13'h0040, 13'h0000, 32'h3C0, 1'b0);
    check("copy_ram", ram_diff(), 0);
    check("copy_first", mem[0], 8'h40);
    check("copy_last", mem[13'h3BF], 8'hFF);
    tick(1);
    cpu_rd(3'd7, rd); check("copy_status", rd, 8'h40);

    // descending overlapping copy 0x100..0x10F -> 0x101..0x110
    init_pattern();
    set_regs(16'h010F, 16'h0110, 16'd16, 8'h00);
    cpu_wr(3'd7, 8'h05);
    wait_state(ST_DONE, 500, cyc);
    check("desc_cycles", cyc, 64);
    model_copy(13'h010F, 13'h0110, 16, 1'b1);
    check("desc_ram", ram_diff(), 0);
    check("desc_lo", mem[13'h101], 8'h00);
    check("desc_hi", mem[13'h110], 8'h0F);
    check("desc_below", mem[13'h100], 8'h00);
    check("desc_above", mem[13'h111], 8'h11);
    tick(1);
    cpu_rd(3'd7, rd); check("desc_status", rd, 8'h48);

    // fill across the top-of-memory wrap
    init_pattern();
    set_regs(16'h0000, 16'h1FFE, 16'd4, 8'hAA);
    qb = wr_q.size();
    cpu_wr(3'd7, 8'h03);
    wait_state(ST_DONE, 100, cyc);
    check("wrap_cycles", cyc, 8);
    check("wrap_count", wr_q.size() - qb, 4);
    wrap_exp[0] = 13'h1FFE; wrap_exp[1] = 13'h1FFF;
    wrap_exp[2] = 13'h0000; wrap_exp[3] = 13'h0001;
    for (int i = 0; i < 4; i++)
      if (qb + i < wr_q.size()) check("wrap_addr", wr_q[qb + i], wrap_exp[i]);
    model_fill(13'h1FFE, 4, 8'hAA);
    check("wrap_ram", ram_diff(), 0);
    tick(1);
    cpu_rd(3'd7, rd); check("wrap_status", rd, 8'h44);

    // LEN = 0: done at once, no bus request
    bb = breq_cnt;
    set_regs(16'h0000, 16'h0000, 16'h0000, 8'h00);
    cpu_wr(3'd7, 8'h11);
    check("len0_irq", irq, 1);
    check("len0_state", dbg_state, ST_IDLE);
    tick(2);
    check("len0_busreq", breq_cnt - bb, 0);
    cpu_rd(3'd7, rd); check("len0_status", rd, 8'h50);

    // grant dropped for 5 cycles while a read is in flight
    init_pattern();
    set_regs(16'h0200, 16'h0800, 16'd32, 8'h00);
    cpu_wr(3'd7, 8'h01);
    tick(22);
    gnt_en = 1'b0;
    sb = strobe_cnt;
    tick(5);
    check("gnt_low_strobes", strobe_cnt - sb, 0);
    check("gnt_low_state", dbg_state, ST_REQ);
    gnt_en = 1'b1;
    wait_state(ST_DONE, 500, cyc);
    model_copy(13'h0200, 13'h0800, 32, 1'b0);
    check("gnt_ram", ram_diff(), 0);
    tick(1);
    cpu_rd(3'd7, rd); check("gnt_status", rd, 8'h40);

    // abort a fill after 10 bytes
    init_pattern();
    set_regs(16'h0000, 16'h0300, 16'd100, 8'h77);
    wb = wr_cnt;
    cpu_wr(3'd7, 8'h03);
    k = 0;
    while (wr_cnt - wb < 10 && k < 200) begin tick(1); k++; end
    cpu_wr(3'd7, 8'h08);
    wait_state(ST_DONE, 10, cyc);
    nw = wr_cnt - wb;
    check("abort_writes", 32'(nw >= 10 && nw <= 11), 32'd1);
    check("abort_irq_off", irq, 0);
    model_fill(13'h0300, nw, 8'h77);
    check("abort_ram", ram_diff(), 0);
    tick(1);
    cpu_rd(3'd7, rd); check("abort_status", rd, 8'h44);

    // SRC writes ignored while busy
    init_pattern();
    set_regs(16'h0123, 16'h1000, 16'd32, 8'h00);
    cpu_wr(3'd7, 8'h01);
    cpu_wr(3'd0, 8'hFF);
    cpu_wr(3'd1, 8'h1F);
    cpu_rd(3'd7, rd); check("lock_busy_status", rd, 8'h80);
    wait_state(ST_DONE, 500, cyc);
    tick(1);
    cpu_rd(3'd0, rd); check("lock_src_lo", rd, 8'h23);
    cpu_rd(3'd1, rd); check("lock_src_hi", rd, 8'h01);
    model_copy(13'h0123, 13'h1000, 32, 1'b0);
    check("lock_ram", ram_diff(), 0);

    // reset in the middle of a fill
    set_regs(16'h0000, 16'h0400, 16'd200, 8'h99);
    cpu_wr(3'd7, 8'h03);
    tick(7);
    reset = 1'b0;
    tick(1);
    check("midrst_busreq", ram_if.busreq, 0);
    check("midrst_sel", ram_if.m_sel_ram, 0);
    check("midrst_we", ram_if.m_we, 0);
    check("midrst_state", dbg_state, ST_IDLE);
    wb = wr_cnt;
    tick(5);
    check("midrst_no_writes", wr_cnt - wb, 0);
    reset = 1'b1;
    tick(1);
    cpu_rd(3'd7, rd); check("midrst_status", rd, 8'h00);
    cpu_rd(3'd4, rd); check("midrst_len_lo", rd, 8'h00);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
